// File: rtl/alu_issue.sv
// Issue/writeback controller wrapped around a combinational ALU: 4-entry register file, 3-cycle IDLE/READ/EXEC sequence.
// Define ALU_ISSUE_R0_ZERO_EN to hardwire r0 to zero.
module alu_issue #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_op,
    input  logic [1:0]   in_rd,
    input  logic [1:0]   in_rs1,
    input  logic [1:0]   in_rs2,
    input  logic         in_use_imm,
    input  logic [N-1:0] in_imm,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_op,
    input  logic [N-1:0] alu_y,
    input  logic         alu_z,
    input  logic         alu_n,
    input  logic         alu_c,
    input  logic         alu_v,
    output logic [3:0]   flags,
    output logic         done,
    input  logic [1:0]   dbg_sel,
    output logic [N-1:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, READ, EXEC} state_t;

    state_t       state, state_nx;
    logic [N-1:0] regs [4];

    logic [3:0]   h_op;
    logic [1:0]   h_rd, h_rs1, h_rs2;
    logic         h_use_imm;
    logic [N-1:0] h_imm;

    logic         latch_en, read_en, exec_en, wb_en;

    function automatic logic [N-1:0] rd_reg(input logic [1:0] idx);
`ifdef ALU_ISSUE_R0_ZERO_EN
        return (idx == 2'd0) ? '0 : regs[idx];
`else
        return regs[idx];
`endif
    endfunction

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        latch_en = 1'b0;
        read_en  = 1'b0;
        exec_en  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    latch_en = 1'b1;
                    state_nx = READ;
                end
            end
            READ: begin
                read_en  = 1'b1;
                state_nx = EXEC;
            end
            EXEC: begin
                exec_en  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef ALU_ISSUE_R0_ZERO_EN
    assign wb_en = exec_en && (h_rd != 2'd0);
`else
    assign wb_en = exec_en;
`endif

    assign dbg_data = rd_reg(dbg_sel);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_op      <= '0;
            h_rd      <= '0;
            h_rs1     <= '0;
            h_rs2     <= '0;
            h_use_imm <= 1'b0;
            h_imm     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            flags     <= '0;
            done      <= 1'b0;
        end else begin
            done <= exec_en;
            if (latch_en) begin
                h_op      <= in_op;
                h_rd      <= in_rd;
                h_rs1     <= in_rs1;
                h_rs2     <= in_rs2;
                h_use_imm <= in_use_imm;
                h_imm     <= in_imm;
            end
            // Operands are sampled here, one edge before writeback, so aliased rd always sees old values.
            if (read_en) begin
                alu_a  <= rd_reg(h_rs1);
                alu_b  <= h_use_imm ? h_imm : rd_reg(h_rs2);
                alu_op <= h_op;
            end
            if (exec_en) begin
                flags <= {alu_z, alu_n, alu_c, alu_v};
            end
        end
    end

    // NOTE: the register file is only four words, so it is flop-based and cleared by reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[h_rd] <= alu_y;
        end
    end

endmodule
